load_store_unit: RTL and testbench

Pipeline-side initiator for the data `memory` block. It accepts one load or store per transaction from the MEM stage and drives the memory's `ce`/`wr_en`/`rd_en`/address/store-data port. It waits out the memory read latency, then returns sign- or zero-extended byte/half/word load data. Sub-word stores are done as read-modify-write, because the memory is word-addressed with no byte enables.

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - pipeline-side load/store initiator for a word-addressed data memory
//
// Accepts one load or store per request handshake. It drives a word-addressed memory
// that has no byte enables. Sub-word stores are therefore done as read-modify-write.
// Load results are returned as sign- or zero-extended byte, half or word values.
//
// Ports:
//   lsu_clk, lsu_rst            clock (rising edge), asynchronous active-high reset
//   lsu_i_req_valid/o_req_ready request handshake; ready only while idle
//   lsu_i_is_store/size/unsigned/addr/store_data  request fields (byte address)
//   lsu_o_load_valid/load_data  one-cycle result pulse; data held until next load
//   lsu_o_misalign              one-cycle pulse for a rejected request
//   lsu_o_busy                  high whenever an operation is in flight
//   lsu_o_ce/wr_en/rd_en/addr/store_data, lsu_i_load_data  memory port (word address)
module load_store_unit #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  lsu_clk,
  input  logic                  lsu_rst,
  input  logic                  lsu_i_req_valid,
  output logic                  lsu_o_req_ready,
  input  logic                  lsu_i_is_store,
  input  logic [1:0]            lsu_i_size,
  input  logic                  lsu_i_unsigned,
  input  logic [AWIDTH_MEM-1:0] lsu_i_addr,
  input  logic [DWIDTH-1:0]     lsu_i_store_data,
  output logic                  lsu_o_load_valid,
  output logic [DWIDTH-1:0]     lsu_o_load_data,
  output logic                  lsu_o_misalign,
  output logic                  lsu_o_busy,
  output logic                  lsu_o_ce,
  output logic                  lsu_o_wr_en,
  output logic                  lsu_o_rd_en,
  output logic [AWIDTH_MEM-1:0] lsu_o_addr,
  output logic [DWIDTH-1:0]     lsu_o_store_data,
  input  logic [DWIDTH-1:0]     lsu_i_load_data
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              is_store_q;
  logic              unsigned_q;
  logic [DWIDTH-1:0] sdata_q;
  logic              req_misaligned;

  assign lsu_o_req_ready = (state == IDLE);
  assign lsu_o_busy      = (state != IDLE);

  always_comb begin
    req_misaligned = 1'b0;
    case (lsu_i_size)
      2'b01:   req_misaligned = lsu_i_addr[0];
      2'b10:   req_misaligned = (lsu_i_addr[1:0] != 2'b00);
      2'b11:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the fetched word and extend it.
  function automatic logic [DWIDTH-1:0] extract(input logic [DWIDTH-1:0] w,
                                                input logic [1:0] off,
                                                input logic [1:0] sz,
                                                input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extract = uns ? {{(DWIDTH-8){1'b0}}, b} : {{(DWIDTH-8){b[7]}}, b};
      2'b01:   extract = uns ? {{(DWIDTH-16){1'b0}}, h} : {{(DWIDTH-16){h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Overlay the right-aligned store lane(s) onto the word read back from memory.
  function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] w,
                                              input logic [1:0] off,
                                              input logic [1:0] sz,
                                              input logic [DWIDTH-1:0] sd);
    merge = w;
    case (sz)
      2'b00: merge[{off, 3'b000} +: 8] = sd[7:0];
      2'b01: begin
        if (off[1]) merge[31:16] = sd[15:0];
        else        merge[15:0]  = sd[15:0];
      end
      default: merge = sd;
    endcase
  endfunction

  always_ff @(posedge lsu_clk or posedge lsu_rst) begin
    if (lsu_rst) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      off_q            <= 2'b00;
      size_q           <= 2'b00;
      is_store_q       <= 1'b0;
      unsigned_q       <= 1'b0;
      sdata_q          <= '0;
      lsu_o_load_valid <= 1'b0;
      lsu_o_load_data  <= '0;
      lsu_o_misalign   <= 1'b0;
      lsu_o_ce         <= 1'b0;
      lsu_o_wr_en      <= 1'b0;
      lsu_o_rd_en      <= 1'b0;
      lsu_o_addr       <= '0;
      lsu_o_store_data <= '0;
    end else begin
      lsu_o_load_valid <= 1'b0;
      lsu_o_misalign   <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_i_req_valid) begin
            if (req_misaligned) begin
              lsu_o_misalign <= 1'b1;
            end else begin
              off_q      <= lsu_i_addr[1:0];
              size_q     <= lsu_i_size;
              is_store_q <= lsu_i_is_store;
              unsigned_q <= lsu_i_unsigned;
              sdata_q    <= lsu_i_store_data;
              lsu_o_ce   <= 1'b1;
              lsu_o_addr <= lsu_i_addr >> 2;
              // Full-word stores need no read-back; everything else reads first.
              if (lsu_i_is_store && lsu_i_size == 2'b10) begin
                lsu_o_wr_en      <= 1'b1;
                lsu_o_store_data <= lsu_i_store_data;
                state            <= WRITE;
              end else begin
                lsu_o_rd_en <= 1'b1;
                state       <= READ;
              end
            end
          end
        end
        READ: begin
          lsu_o_rd_en <= 1'b0;
          cnt         <= 3'(RD_LATENCY);
          state       <= WAIT;
        end
        WAIT: begin
          // Count reaches 1 on the RD_LATENCY-th edge after the read was sampled.
          if (cnt == 3'd1) begin
            cnt <= 3'd0;
            if (is_store_q) begin
              lsu_o_store_data <= merge(lsu_i_load_data, off_q, size_q, sdata_q);
              lsu_o_wr_en      <= 1'b1;
              state            <= WRITE;
            end else begin
              lsu_o_load_data  <= extract(lsu_i_load_data, off_q, size_q, unsigned_q);
              lsu_o_load_valid <= 1'b1;
              lsu_o_ce         <= 1'b0;
              lsu_o_addr       <= '0;
              state            <= IDLE;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WRITE: begin
          lsu_o_wr_en      <= 1'b0;
          lsu_o_ce         <= 1'b0;
          lsu_o_addr       <= '0;
          lsu_o_store_data <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit (latency 1 and 3)
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: RD_LATENCY = 1 instance, index 1: RD_LATENCY = 3 instance.
  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        is_store [2];
  logic [1:0]  size [2];
  logic        uns [2];
  logic [31:0] a_in [2];
  logic [31:0] sd_in [2];
  logic        load_valid [2];
  logic [31:0] load_data [2];
  logic        misalign [2];
  logic        busy [2];
  logic        ce [2];
  logic        wr_en [2];
  logic        rd_en [2];
  logic [31:0] a_out [2];
  logic [31:0] sd_out [2];
  logic [31:0] rdata [2];

  int total = 0;
  int bad = 0;

  load_store_unit #(.DWIDTH(32), .AWIDTH_MEM(32), .RD_LATENCY(1)) u0 (
    .lsu_clk(clk), .lsu_rst(rst[0]), .lsu_i_req_valid(req_valid[0]), .lsu_o_req_ready(req_ready[0]),
    .lsu_i_is_store(is_store[0]), .lsu_i_size(size[0]), .lsu_i_unsigned(uns[0]), .lsu_i_addr(a_in[0]),
    .lsu_i_store_data(sd_in[0]), .lsu_o_load_valid(load_valid[0]), .lsu_o_load_data(load_data[0]),
    .lsu_o_misalign(misalign[0]), .lsu_o_busy(busy[0]), .lsu_o_ce(ce[0]), .lsu_o_wr_en(wr_en[0]),
    .lsu_o_rd_en(rd_en[0]), .lsu_o_addr(a_out[0]), .lsu_o_store_data(sd_out[0]), .lsu_i_load_data(rdata[0])
  );

  load_store_unit #(.DWIDTH(32), .AWIDTH_MEM(32), .RD_LATENCY(3)) u1 (
    .lsu_clk(clk), .lsu_rst(rst[1]), .lsu_i_req_valid(req_valid[1]), .lsu_o_req_ready(req_ready[1]),
    .lsu_i_is_store(is_store[1]), .lsu_i_size(size[1]), .lsu_i_unsigned(uns[1]), .lsu_i_addr(a_in[1]),
    .lsu_i_store_data(sd_in[1]), .lsu_o_load_valid(load_valid[1]), .lsu_o_load_data(load_data[1]),
    .lsu_o_misalign(misalign[1]), .lsu_o_busy(busy[1]), .lsu_o_ce(ce[1]), .lsu_o_wr_en(wr_en[1]),
    .lsu_o_rd_en(rd_en[1]), .lsu_o_addr(a_out[1]), .lsu_o_store_data(sd_out[1]), .lsu_i_load_data(rdata[1])
  );

  // Memory models plus activity counters; read data is only valid on the exact latency edge.
  logic [31:0] mem [2][16] = '{default: '0};
  logic [31:0] pipe [2][4];
  logic [31:0] last_wa [2];
  int cyc = 0;
  int n_wr [2];
  int n_rd [2];
  int n_ce [2];
  int n_lv [2];
  int n_mis [2];
  bit both_hi [2];
  bit sd_leak [2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (ce[g] && wr_en[g]) begin
        mem[g][a_out[g][3:0]] <= sd_out[g];
        last_wa[g] <= a_out[g];
        n_wr[g] <= n_wr[g] + 1;
      end
      if (ce[g] && rd_en[g]) n_rd[g] <= n_rd[g] + 1;
      if (ce[g]) n_ce[g] <= n_ce[g] + 1;
      if (load_valid[g]) n_lv[g] <= n_lv[g] + 1;
      if (misalign[g]) n_mis[g] <= n_mis[g] + 1;
      if (wr_en[g] && rd_en[g]) both_hi[g] <= 1'b1;
      if (!wr_en[g] && sd_out[g] != 32'h0) sd_leak[g] <= 1'b1;
      pipe[g][0] <= (ce[g] && rd_en[g]) ? mem[g][a_out[g][3:0]] : 32'hBAD0BAD0;
      for (int i = 1; i < 4; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end

  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];

  task automatic issue(input int d, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] sd, output int acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[d] === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_ready d=%0d: ready=%b required 1 within 50 cycles", d, req_ready[d]);
    end
    req_valid[d] = 1'b1; is_store[d] = st; size[d] = sz; uns[d] = un; a_in[d] = a; sd_in[d] = sd;
    @(posedge clk);
    #1;
    acc = cyc;
    // Scramble the request fields so only latched values can produce correct results.
    req_valid[d] = 1'b0; is_store[d] = ~st; size[d] = 2'b11; uns[d] = ~un;
    a_in[d] = 32'hFFFF_FFFF; sd_in[d] = 32'h5A5A_5A5A;
  endtask

  task automatic wait_idle(input int d, output int c);
    bit ok;
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[d] === 1'b1) begin ok = 1'b1; c = cyc; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_idle d=%0d: still busy after 40 cycles", d); end
  endtask

  task automatic wait_load(input int d, output logic [31:0] data, output int c);
    bit ok;
    ok = 1'b0;
    data = 32'hX;
    c = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (load_valid[d] === 1'b1) begin ok = 1'b1; data = load_data[d]; c = cyc; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_load d=%0d: no load_valid within 40 cycles", d); end
  endtask

  task automatic test_reset();
    int c0, r0, l0;
    @(negedge clk);
    total++;
    if ({ce[0], rd_en[0], wr_en[0], load_valid[0], misalign[0], busy[0], req_ready[0]} !== 7'b0000001 ||
        a_out[0] !== 32'h0 || sd_out[0] !== 32'h0 || load_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: ctl=%b addr=%h sd=%h ld=%h required ctl=0000001 rest 0",
               {ce[0], rd_en[0], wr_en[0], load_valid[0], misalign[0], busy[0], req_ready[0]},
               a_out[0], sd_out[0], load_data[0]);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    issue(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, c0);
    total++;
    if (rd_en[0] !== 1'b1) begin bad++; $display("FAIL reset_pre_read: rd_en=%b required 1", rd_en[0]); end
    #2 rst[0] = 1'b1;
    #1;
    total++;
    if ({ce[0], rd_en[0], wr_en[0], load_valid[0], misalign[0], busy[0], req_ready[0]} !== 7'b0000001 ||
        a_out[0] !== 32'h0 || sd_out[0] !== 32'h0) begin
      bad++;
      $display("FAIL reset_async: ctl=%b addr=%h sd=%h required ctl=0000001 addr=0 sd=0",
               {ce[0], rd_en[0], wr_en[0], load_valid[0], misalign[0], busy[0], req_ready[0]}, a_out[0], sd_out[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    r0 = n_rd[0]; l0 = n_lv[0];
    repeat (4) @(negedge clk);
    total++;
    if (n_rd[0] != r0 || n_lv[0] != l0 || req_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_quiet: reads=%0d lv=%0d ready=%b required reads=%0d lv=%0d ready=1",
               n_rd[0], n_lv[0], req_ready[0], r0, l0);
    end
  endtask

  task automatic test_word();
    int c0, c1, w0;
    logic [31:0] d;
    w0 = n_wr[0];
    issue(0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, c0);
    total++;
    if (wr_en[0] !== 1'b1 || rd_en[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL word_store_write: wr=%b rd=%b ready=%b required 1 0 0", wr_en[0], rd_en[0], req_ready[0]);
    end
    wait_idle(0, c1);
    total++;
    if (c1 - c0 != 1) begin bad++; $display("FAIL word_store_occupancy: %0d required 1", c1 - c0); end
    total++;
    if (n_wr[0] - w0 != 1 || last_wa[0] !== 32'h1 || mem[0][1] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word_store_mem: writes=%0d addr=%h word=%h required 1 1 deadbeef",
                      n_wr[0] - w0, last_wa[0], mem[0][1]);
    end
    issue(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load_data: %h required deadbeef", d); end
    total++;
    if (c1 - c0 != 2) begin bad++; $display("FAIL word_load_latency: %0d required 2", c1 - c0); end
  endtask

  task automatic test_byte();
    int c0, c1;
    logic [31:0] d;
    issue(0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h123456A5, c0);
    total++;
    if (rd_en[0] !== 1'b1 || wr_en[0] !== 1'b0) begin
      bad++; $display("FAIL byte_store_read: rd=%b wr=%b required 1 0", rd_en[0], wr_en[0]);
    end
    wait_idle(0, c1);
    total++;
    if (c1 - c0 != 3) begin bad++; $display("FAIL byte_store_occupancy: %0d required 3", c1 - c0); end
    total++;
    if (mem[0][1] !== 32'hDEADA5EF || last_wa[0] !== 32'h1) begin
      bad++; $display("FAIL byte_store_mem: word=%h addr=%h required deada5ef 1", mem[0][1], last_wa[0]);
    end
    issue(0, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'hFFFFFFA5) begin bad++; $display("FAIL byte_load_signed: %h required ffffffa5", d); end
    issue(0, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'h000000A5) begin bad++; $display("FAIL byte_load_unsigned: %h required 000000a5", d); end
    issue(0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'hFFFFFFEF) begin bad++; $display("FAIL byte_load_lane0: %h required ffffffef", d); end
    issue(0, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'h000000DE) begin bad++; $display("FAIL byte_load_lane3: %h required 000000de", d); end
  endtask

  task automatic test_half();
    int c0, c1;
    logic [31:0] d;
    issue(0, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'hFFFFDEAD) begin bad++; $display("FAIL half_load_signed: %h required ffffdead", d); end
    issue(0, 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (d !== 32'h0000A5EF) begin bad++; $display("FAIL half_load_unsigned: %h required 0000a5ef", d); end
    issue(0, 1'b1, 2'b01, 1'b0, 32'h2, 32'hABCD1234, c0);
    wait_idle(0, c1);
    total++;
    if (mem[0][0] !== 32'h12340000 || last_wa[0] !== 32'h0) begin
      bad++; $display("FAIL half_store_mem: word=%h addr=%h required 12340000 0", mem[0][0], last_wa[0]);
    end
  endtask

  task automatic test_misalign();
    int ce0, lv0, m0;
    logic [31:0] va [3] = '{32'h2, 32'h3, 32'h0};
    logic [1:0]  vs [3] = '{2'b10, 2'b01, 2'b11};
    ce0 = n_ce[0]; lv0 = n_lv[0]; m0 = n_mis[0];
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1; is_store[0] = i[0]; size[0] = vs[i]; a_in[0] = va[i]; uns[0] = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (misalign[0] !== 1'b1 || req_ready[0] !== 1'b1) begin
        bad++; $display("FAIL misalign_pulse%0d: mis=%b ready=%b required 1 1", i, misalign[0], req_ready[0]);
      end
    end
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (misalign[0] !== 1'b0) begin bad++; $display("FAIL misalign_clear: %b required 0", misalign[0]); end
    @(negedge clk);
    total++;
    if (n_mis[0] - m0 != 3 || n_ce[0] != ce0 || n_lv[0] != lv0) begin
      bad++; $display("FAIL misalign_counts: pulses=%0d ce=%0d lv=%0d required 3 0 0",
                      n_mis[0] - m0, n_ce[0] - ce0, n_lv[0] - lv0);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    logic [31:0] d;
    issue(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, c0);
    wait_load(0, d, c1);
    total++;
    if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL b2b_ready_with_valid: %b required 1", req_ready[0]); end
    req_valid[0] = 1'b1; is_store[0] = 1'b0; size[0] = 2'b01; uns[0] = 1'b1; a_in[0] = 32'h2;
    @(posedge clk);
    #1;
    c0 = cyc;
    req_valid[0] = 1'b0;
    total++;
    if (rd_en[0] !== 1'b1 || a_out[0] !== 32'h0) begin
      bad++; $display("FAIL b2b_accept: rd=%b addr=%h required 1 0", rd_en[0], a_out[0]);
    end
    wait_load(0, d, c1);
    total++;
    if (d !== 32'h00001234 || c1 - c0 != 2) begin
      bad++; $display("FAIL b2b_load: data=%h lat=%0d required 00001234 2", d, c1 - c0);
    end
  endtask

  task automatic test_latency3();
    int c0, c1, w0;
    logic [31:0] d;
    issue(1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, c0);
    wait_idle(1, c1);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, c0);
    wait_load(1, d, c1);
    total++;
    if (d !== 32'h11223344 || c1 - c0 != 4) begin
      bad++; $display("FAIL lat3_load: data=%h lat=%0d required 11223344 4", d, c1 - c0);
    end
    issue(1, 1'b1, 2'b00, 1'b0, 32'h9, 32'h00000077, c0);
    wait_idle(1, c1);
    total++;
    if (mem[1][2] !== 32'h11227744 || c1 - c0 != 5) begin
      bad++; $display("FAIL lat3_byte_store: word=%h occ=%0d required 11227744 5", mem[1][2], c1 - c0);
    end
    w0 = n_wr[1];
    issue(1, 1'b1, 2'b00, 1'b0, 32'hA, 32'h00000099, c0);
    @(posedge clk);
    #1;
    total++;
    if ({ce[1], rd_en[1], wr_en[1]} !== 3'b100) begin
      bad++; $display("FAIL lat3_in_wait: ce/rd/wr=%b required 100", {ce[1], rd_en[1], wr_en[1]});
    end
    #1 rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (n_wr[1] != w0 || mem[1][2] !== 32'h11227744 || req_ready[1] !== 1'b1) begin
      bad++; $display("FAIL lat3_reset_abort: writes=%0d word=%h ready=%b required 0 11227744 1",
                      n_wr[1] - w0, mem[1][2], req_ready[1]);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; req_valid[g] = 1'b0; is_store[g] = 1'b0; size[g] = 2'b00;
      uns[g] = 1'b0; a_in[g] = 32'h0; sd_in[g] = 32'h0;
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    test_latency3();
    for (int g = 0; g < 2; g++) begin
      total++;
      if (both_hi[g] || sd_leak[g]) begin
        bad++; $display("FAIL mem_port_rules d=%0d: rd_wr_overlap=%b store_data_leak=%b required 0 0",
                        g, both_hi[g], sd_leak[g]);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
